// File: rtl/stg_4_me_dmem.sv
// Memory (ME) pipeline stage between EX and WB.
//   Owns a DMEM_DEPTH-word data memory with MEM_LAT extra cycles per load/store,
//   stalling upstream while an access is in flight. Resolves branches, latches
//   print values for the display driver and registers the writeback bundle.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   r_me_*                       instruction bundle from EX/ME (held while me_stall=1)
//   me_stall                     combinational hold request to upstream stages
//   br_taken, br_target          combinational branch redirect
//   r_wb_valid/value/rd/RegWrite registered writeback bundle
//   print_value, print_valid     last printed value and "printed since reset"
//   mem_fault                    sticky out-of-range access flag
module stg_4_me_dmem #(
  parameter int unsigned VALUE_W    = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter int unsigned MEM_LAT    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  r_me_valid,
  input  logic [REG_ADDR_W-1:0] r_me_rd,
  input  logic [VALUE_W-1:0]    r_me_aluout,
  input  logic [VALUE_W-1:0]    r_me_storedata,
  input  logic                  r_me_aluzero,
  input  logic                  r_me_RegWrite,
  input  logic                  r_me_MemRead,
  input  logic                  r_me_MemWrite,
  input  logic                  r_me_Branch,
  input  logic [VALUE_W-1:0]    r_me_br_target,
  input  logic                  r_me_PrintValue,
  output logic                  me_stall,
  output logic                  br_taken,
  output logic [VALUE_W-1:0]    br_target,
  output logic                  r_wb_valid,
  output logic [VALUE_W-1:0]    r_wb_value,
  output logic [REG_ADDR_W-1:0] r_wb_rd,
  output logic                  r_wb_RegWrite,
  output logic [VALUE_W-1:0]    print_value,
  output logic                  print_valid,
  output logic                  mem_fault
);

  localparam int unsigned IDX_W = $clog2(DMEM_DEPTH);
  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [VALUE_W-1:0] r_dmem [DMEM_DEPTH];

  logic               w_memop;
  logic               w_store;
  logic               w_load;
  logic               w_in_range;
  logic [IDX_W-1:0]   w_idx;
  logic [VALUE_W-1:0] w_rdata;
  logic               w_done;
  logic               w_mem_done;

  // Decode: a store takes precedence when both MemRead and MemWrite are set.
  assign w_memop    = r_me_valid & (r_me_MemRead | r_me_MemWrite);
  assign w_store    = w_memop & r_me_MemWrite;
  assign w_load     = w_memop & r_me_MemRead & ~r_me_MemWrite;
  assign w_in_range = (r_me_aluout < VALUE_W'(DMEM_DEPTH));
  assign w_idx      = r_me_aluout[IDX_W-1:0];
  assign w_rdata    = w_in_range ? r_dmem[w_idx] : '0;

  // Edge on which the instruction in ME leaves the stage.
  always_comb begin
    w_done = 1'b0;
    if (MEM_LAT == 0) begin
      w_done = r_me_valid;
    end else if (r_state == S_IDLE) begin
      w_done = r_me_valid & ~w_memop;
    end else begin
      w_done = (r_cnt == '0);
    end
  end

  assign w_mem_done = w_done & w_memop;

  // Stall on entry of a memop and for every BUSY cycle except the last.
  assign me_stall = (MEM_LAT == 0) ? 1'b0
                  : ((r_state == S_IDLE) ? w_memop : (r_cnt != '0));

  assign br_taken  = r_me_valid & r_me_Branch & r_me_aluzero & ~w_memop;
  assign br_target = r_me_br_target;

  // Data memory: not reset; a store in flight when reset hits is dropped.
  always_ff @(posedge clock) begin
    if (!reset && w_mem_done && w_store && w_in_range) begin
      r_dmem[w_idx] <= r_me_storedata;
    end
  end

  // Access-latency FSM and registered WB / print / fault state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_value    <= '0;
      r_wb_rd       <= '0;
      r_wb_RegWrite <= 1'b0;
      print_value   <= '0;
      print_valid   <= 1'b0;
      mem_fault     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((MEM_LAT != 0) && w_memop) begin
            r_state <= S_BUSY;
            r_cnt   <= CNT_W'(MEM_LAT - 1);
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      r_wb_valid    <= w_done;
      r_wb_RegWrite <= w_done & r_me_RegWrite;
      if (w_done) begin
        r_wb_value <= w_load ? w_rdata : r_me_aluout;
        r_wb_rd    <= r_me_rd;
        if (r_me_PrintValue) begin
          print_value <= r_me_aluout;
          print_valid <= 1'b1;
        end
        if (w_memop && !w_in_range) begin
          mem_fault <= 1'b1;
        end
      end
    end
  end

endmodule
